ring_phase_monitor: RTL and testbench
=====================================

# ring_phase_monitor

Downstream checker and decoder for the 4-bit one-hot ring counter. It samples the ring state and checks every step against the legal rotation 1000→0100→0010→0001→1000. It encodes the active phase to a binary index, counts completed revolutions and flags illegal states or transitions. It sits between the ring counter and the phase-sequenced logic that consumes `phase_idx`.

## Interface
- `WIDTH`, 4: ring length. One-hot width of `ring_in`.
- `REV_W`, 8: width of the revolution counter.
- `ERR_W`, 4: width of the saturating error counter.

- `clk`  in  1  rising-edge clock, shared with the ring counter.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  sample strobe. When low, all state holds and `rev_tick` is 0.
- `ring_in`  in  WIDTH  ring counter output.
- `clear_err`  in  1  clears `err_illegal` and `err_count`, and exits FAULT.
- `phase_idx`  out  clog2(WIDTH)  active phase: 0 for MSB set, WIDTH-1 for LSB set.
- `phase_valid`  out  1  `phase_idx` is meaningful (LOCKED only).
- `locked`  out  1  FSM is in LOCKED.
- `rev_tick`  out  1  one-cycle pulse on each wrap from LSB to MSB.
- `rev_count`  out  REV_W  completed revolutions, wraps modulo 2^REV_W.
- `err_illegal`  out  1  sticky error flag.
- `err_count`  out  ERR_W  error events, saturates at all-ones.

## Operation
- Definitions:
  - A sample is `ring_in` at a rising edge with `enable`=1.
  - `onehot` means exactly one bit of the sample is set.
  - `expected` is the previous accepted sample rotated right, with LSB wrapping to MSB.
- FSM states: IDLE, LOCKED, FAULT. Reset enters IDLE.
- IDLE:
  - sample 0 → stay IDLE, no error (this is the ring counter's reset value).
  - sample onehot → LOCKED; capture the sample; `phase_idx` = its index.
  - any other sample → FAULT, error event.
- LOCKED:
  - sample == `expected` → stay LOCKED; update `phase_idx`.
    - If the previous sample was LSB and the new one is MSB: `rev_tick`=1 and `rev_count`+1.
  - sample 0 → IDLE, no error (upstream reset mid-run).
  - any other sample (skip, repeat, multi-hot) → FAULT, error event.
- FAULT:
  - `phase_valid`=0.
  - sample 0 or `clear_err` → IDLE. This follows the ring counter's self-recovery to 0000.
  - A onehot sample does not relock directly.
- Error event: `err_illegal` is set; `err_count` increments and saturates at 2^ERR_W−1.
- `clear_err` with an error event in the same cycle: the clear applies first, giving `err_illegal`=1, `err_count`=1, state FAULT.
- `rev_count` is unaffected by errors and `clear_err`; only `reset` clears it.
- The first lock from IDLE never generates `rev_tick`, even if the first sample is MSB.

## Timing
- All outputs are registered. Latency is 1 cycle from sample edge to `phase_idx`, `phase_valid`, `locked`, `rev_tick` and error outputs.
- Reset values: `phase_idx`=0, `phase_valid`=0, `locked`=0, `rev_tick`=0, `rev_count`=0, `err_illegal`=0, `err_count`=0, state IDLE.
- `reset` has priority over `enable` and `clear_err`, and clears everything in the same edge, including mid-revolution.
- `phase_valid` == `locked` at all times.
- `rev_tick` is high for exactly one cycle per wrap. It is never high with `enable`=0 on the preceding edge.
- `enable`=0 freezes `expected`. A resumed ring matching `expected` is legal.
- `clear_err` is honoured regardless of `enable`.

## Structure
- Shared package `ring_pkg`:
  - state encoding (IDLE=0, LOCKED=1, FAULT=2);
  - default `WIDTH`;
  - rotate-right helper function.
- Sub-module `ring_onehot_decode` (combinational):
  - inputs: `ring_in`;
  - outputs: `is_zero`, `is_onehot`, `idx`.
- Top module holds the FSM, the previous-sample register, `rev_count` and the error counter.

## Test plan
- Reset, then drive 0000 for 2 samples, then 1000,0100,0010,0001,1000 → `locked`=1 one cycle after 1000; `phase_idx` 0,1,2,3,0; one `rev_tick`; `rev_count`=1; no error.
- While LOCKED at 0100, drive 0001 (skip) → FAULT; `err_illegal`=1, `err_count`=1, `phase_valid`=0. Then drive 0000 → IDLE. Then drive 1000 → relocked, `err_illegal` still 1.
- Drive 1100 from IDLE 16 times, with 0000 between each → `err_count` saturates at 15.
- While LOCKED at 0010, drop `enable` for 3 cycles. Resume with 0001 → no error, `phase_idx`=3. Next sample 1000 → `rev_tick`.
- Raise `clear_err` on the same edge as an illegal sample 0110 → `err_illegal`=1, `err_count`=1, FAULT.
- Run 256 clean revolutions → `rev_count` wraps to 0. Assert `reset` mid-revolution → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the ring counter checker: FSM encoding, default ring
// length and the rotation that predicts the next legal ring state.
package ring_pkg;

   localparam int RING_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } ring_state_t;

   // Rotate the low w bits of v right by one; bit 0 wraps to bit w-1.
   // Bits above w-1 must be zero on entry.
   function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned w);
      return (v >> 1) | ({31'b0, v[0]} << (w - 1));
   endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational classifier for a ring sample: all-zero, one-hot, and the
// phase index of the set bit (0 for MSB, WIDTH-1 for LSB).
module ring_onehot_decode
   import ring_pkg::*;
#(
   parameter int WIDTH = RING_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] ring_in,
   output logic             is_zero,
   output logic             is_onehot,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] contrib [WIDTH];

   // Each set bit contributes its phase number; only meaningful when one-hot.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_idx
      assign contrib[gi] = ring_in[gi] ? IDX_W'(WIDTH - 1 - gi) : '0;
   end

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         idx = idx | contrib[i];
      end
   end

   assign is_zero   = (ring_in == '0);
   assign is_onehot = !is_zero && ((ring_in & (ring_in - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter against its legal rotation, decodes the phase,
// counts revolutions and keeps a sticky, saturating error record.
module ring_phase_monitor
   import ring_pkg::*;
#(
   parameter int WIDTH = RING_WIDTH,
   parameter int REV_W = 8,
   parameter int ERR_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [WIDTH-1:0]         ring_in,
   input  logic                     clear_err,
   output logic [$clog2(WIDTH)-1:0] phase_idx,
   output logic                     phase_valid,
   output logic                     locked,
   output logic                     rev_tick,
   output logic [REV_W-1:0]         rev_count,
   output logic                     err_illegal,
   output logic [ERR_W-1:0]         err_count
);

   localparam int IDX_W = $clog2(WIDTH);

   ring_state_t      state_reg;
   logic [WIDTH-1:0] prev_reg;
   logic [IDX_W-1:0] phase_idx_reg;
   logic             locked_reg;
   logic             rev_tick_reg;
   logic [REV_W-1:0] rev_count_reg;
   logic             err_illegal_reg;
   logic [ERR_W-1:0] err_count_reg;

   logic             is_zero;
   logic             is_onehot;
   logic [IDX_W-1:0] dec_idx;
   logic [WIDTH-1:0] expected;
   logic [ERR_W-1:0] err_count_next;

   ring_onehot_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_decode (
      .ring_in   (ring_in),
      .is_zero   (is_zero),
      .is_onehot (is_onehot),
      .idx       (dec_idx)
   );

   assign expected = WIDTH'(rotr(32'(prev_reg), WIDTH));

   // A clear in the same cycle as an error restarts the count from this event.
   always_comb begin
      err_count_next = err_count_reg;
      if (clear_err)
         err_count_next = ERR_W'(1);
      else if (err_count_reg != '1)
         err_count_next = err_count_reg + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         prev_reg        <= '0;
         phase_idx_reg   <= '0;
         locked_reg      <= 1'b0;
         rev_tick_reg    <= 1'b0;
         rev_count_reg   <= '0;
         err_illegal_reg <= 1'b0;
         err_count_reg   <= '0;
      end else begin
         rev_tick_reg <= 1'b0;

         if (clear_err) begin
            err_illegal_reg <= 1'b0;
            err_count_reg   <= '0;
            if (state_reg == ST_FAULT) begin
               state_reg  <= ST_IDLE;
               locked_reg <= 1'b0;
            end
         end

         // Later assignments below override the clear when an error lands too.
         if (enable) begin
            unique case (state_reg)
               ST_IDLE: begin
                  if (is_onehot) begin
                     state_reg     <= ST_LOCKED;
                     locked_reg    <= 1'b1;
                     prev_reg      <= ring_in;
                     phase_idx_reg <= dec_idx;
                  end else if (!is_zero) begin
                     state_reg       <= ST_FAULT;
                     err_illegal_reg <= 1'b1;
                     err_count_reg   <= err_count_next;
                  end
               end
               ST_LOCKED: begin
                  if (ring_in == expected) begin
                     prev_reg      <= ring_in;
                     phase_idx_reg <= dec_idx;
                     if (prev_reg[0]) begin
                        rev_tick_reg  <= 1'b1;
                        rev_count_reg <= rev_count_reg + REV_W'(1);
                     end
                  end else if (is_zero) begin
                     state_reg  <= ST_IDLE;
                     locked_reg <= 1'b0;
                  end else begin
                     state_reg       <= ST_FAULT;
                     locked_reg      <= 1'b0;
                     err_illegal_reg <= 1'b1;
                     err_count_reg   <= err_count_next;
                  end
               end
               ST_FAULT: begin
                  if (is_zero)
                     state_reg <= ST_IDLE;
               end
               default: begin
                  state_reg  <= ST_IDLE;
                  locked_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign phase_idx   = phase_idx_reg;
   assign phase_valid = locked_reg;
   assign locked      = locked_reg;
   assign rev_tick    = rev_tick_reg;
   assign rev_count   = rev_count_reg;
   assign err_illegal = err_illegal_reg;
   assign err_count   = err_count_reg;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: stimulus pushes hand-computed
// expectations, an independent monitor pops and compares after every edge.
module tb_ring_phase_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] ring_in = 4'b0000;
   logic       clear_err = 1'b0;
   logic [1:0] phase_idx;
   logic       phase_valid;
   logic       locked;
   logic       rev_tick;
   logic [7:0] rev_count;
   logic       err_illegal;
   logic [3:0] err_count;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      name;
      logic       lk;
      logic [1:0] ph;
      logic       tk;
      logic [7:0] rc;
      logic       ei;
      logic [3:0] ec;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   ring_phase_monitor #(.WIDTH(4), .REV_W(8), .ERR_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .ring_in     (ring_in),
      .clear_err   (clear_err),
      .phase_idx   (phase_idx),
      .phase_valid (phase_valid),
      .locked      (locked),
      .rev_tick    (rev_tick),
      .rev_count   (rev_count),
      .err_illegal (err_illegal),
      .err_count   (err_count)
   );

   // Apply one cycle of inputs and queue what the outputs must be after the edge.
   task automatic step(input string name, input logic rst, input logic en,
                       input logic [3:0] r, input logic clr,
                       input logic lk, input logic [1:0] ph, input logic tk,
                       input logic [7:0] rc, input logic ei, input logic [3:0] ec);
      exp_t e;
      @(negedge clk);
      reset     = rst;
      enable    = en;
      ring_in   = r;
      clear_err = clr;
      e.name = name; e.lk = lk; e.ph = ph; e.tk = tk;
      e.rc = rc; e.ei = ei; e.ec = ec;
      exp_q.push_back(e);
   endtask

   // Monitor: every edge produces an output sample; compare it to the queue head.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e = exp_q.pop_front();
            ok = (locked == e.lk) && (phase_valid == e.lk) && (rev_tick == e.tk) &&
                 (rev_count == e.rc) && (err_illegal == e.ei) && (err_count == e.ec) &&
                 (!e.lk || phase_idx == e.ph);
            tests++;
            if (!ok) begin
               fails++;
               $display("FAIL %s: got lk=%0d pv=%0d ph=%0d tk=%0d rc=%0d ei=%0d ec=%0d, want lk=%0d ph=%0d tk=%0d rc=%0d ei=%0d ec=%0d",
                        e.name, locked, phase_valid, phase_idx, rev_tick, rev_count,
                        err_illegal, err_count, e.lk, e.ph, e.tk, e.rc, e.ei, e.ec);
            end else begin
               $display("[TB] %s ok: lk=%0d ph=%0d tk=%0d rc=%0d ei=%0d ec=%0d",
                        e.name, locked, phase_idx, rev_tick, rev_count, err_illegal, err_count);
            end
         end
      end
   end

   initial begin
      logic [3:0] rv;
      logic [7:0] rc;
      int         wait_cycles;

      // Reset and a clean first revolution
      step("reset",      1, 0, 4'b0000, 0,  0, 0, 0, 0, 0, 0);
      step("idle0_a",    0, 1, 4'b0000, 0,  0, 0, 0, 0, 0, 0);
      step("idle0_b",    0, 1, 4'b0000, 0,  0, 0, 0, 0, 0, 0);
      step("lock_1000",  0, 1, 4'b1000, 0,  1, 0, 0, 0, 0, 0);
      step("ph_0100",    0, 1, 4'b0100, 0,  1, 1, 0, 0, 0, 0);
      step("ph_0010",    0, 1, 4'b0010, 0,  1, 2, 0, 0, 0, 0);
      step("ph_0001",    0, 1, 4'b0001, 0,  1, 3, 0, 0, 0, 0);
      step("wrap_1000",  0, 1, 4'b1000, 0,  1, 0, 1, 1, 0, 0);

      // Skip error, recovery through zero, relock keeps sticky flag
      step("ph_0100b",   0, 1, 4'b0100, 0,  1, 1, 0, 1, 0, 0);
      step("skip_0001",  0, 1, 4'b0001, 0,  0, 0, 0, 1, 1, 1);
      step("fault_zero", 0, 1, 4'b0000, 0,  0, 0, 0, 1, 1, 1);
      step("relock",     0, 1, 4'b1000, 0,  1, 0, 0, 1, 1, 1);

      // Clear while locked keeps lock; then saturate the error counter
      step("clr_locked", 0, 0, 4'b0000, 1,  1, 0, 0, 1, 0, 0);
      step("to_idle",    0, 1, 4'b0000, 0,  0, 0, 0, 1, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         step($sformatf("multihot_%0d", k), 0, 1, 4'b1100, 0,
              0, 0, 0, 1, 1, (k > 15) ? 4'd15 : 4'(k));
         step($sformatf("multihot_z%0d", k), 0, 1, 4'b0000, 0,
              0, 0, 0, 1, 1, (k > 15) ? 4'd15 : 4'(k));
      end

      // Enable gap freezes expected; resumed ring is legal and ticks on wrap
      step("clr_idle",   0, 0, 4'b0000, 1,  0, 0, 0, 1, 0, 0);
      step("en_1000",    0, 1, 4'b1000, 0,  1, 0, 0, 1, 0, 0);
      step("en_0100",    0, 1, 4'b0100, 0,  1, 1, 0, 1, 0, 0);
      step("en_0010",    0, 1, 4'b0010, 0,  1, 2, 0, 1, 0, 0);
      step("hold_a",     0, 0, 4'b0110, 0,  1, 2, 0, 1, 0, 0);
      step("hold_b",     0, 0, 4'b0001, 0,  1, 2, 0, 1, 0, 0);
      step("hold_c",     0, 0, 4'b1000, 0,  1, 2, 0, 1, 0, 0);
      step("resume_0001",0, 1, 4'b0001, 0,  1, 3, 0, 1, 0, 0);
      step("resume_wrap",0, 1, 4'b1000, 0,  1, 0, 1, 2, 0, 0);

      // Clear and error on the same edge; FAULT ignores a one-hot sample
      step("clr_and_err",0, 1, 4'b0110, 1,  0, 0, 0, 2, 1, 1);
      step("fault_hold", 0, 1, 4'b0100, 0,  0, 0, 0, 2, 1, 1);
      step("fault_clr",  0, 1, 4'b1000, 1,  0, 0, 0, 2, 0, 0);
      step("idle_again", 0, 1, 4'b0000, 0,  0, 0, 0, 2, 0, 0);

      // 256 revolutions from reset wrap rev_count back to 0
      step("reset2",     1, 1, 4'b1000, 1,  0, 0, 0, 0, 0, 0);
      step("rlock_1000", 0, 1, 4'b1000, 0,  1, 0, 0, 0, 0, 0);
      rc = 8'd0;
      for (int rev = 0; rev < 256; rev++) begin
         for (int p = 1; p <= 4; p++) begin
            rv = 4'b1000 >> (p % 4);
            if (p == 4) rc = rc + 8'd1;
            step($sformatf("rev%0d_p%0d", rev, p % 4), 0, 1, rv, 0,
                 1, 2'(p % 4), (p == 4), rc, 0, 0);
         end
      end
      step("mid_0100",   0, 1, 4'b0100, 0,  1, 1, 0, 0, 0, 0);
      step("mid_0010",   0, 1, 4'b0010, 0,  1, 2, 0, 0, 0, 0);
      step("mid_reset",  1, 1, 4'b0001, 1,  0, 0, 0, 0, 0, 0);
      step("post_reset", 0, 1, 4'b0000, 0,  0, 0, 0, 0, 0, 0);

      @(negedge clk);
      enable = 1'b0;
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
